// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the sizing rule for the ack timeout counter.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_WRITE
  } lsu_state_e;

  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts and extends load data from a memory word and
// merges sub-word store data into the previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] read_word,
  input  logic [15:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = read_word[{offset, 3'b000} +: 8];
    half_val = offset[1] ? read_word[31:16] : read_word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
      F3_BU:   load_data = {24'b0, byte_val};
      F3_H:    load_data = {{16{half_val[15]}}, half_val};
      F3_HU:   load_data = {16'b0, half_val};
      default: load_data = read_word;
    endcase

    // Only SB and SH reach the merge path; SW bypasses it entirely.
    merged_word = read_word;
    if (funct3 == F3_H) begin
      if (offset[1]) merged_word[31:16] = store_data;
      else           merged_word[15:0]  = store_data;
    end else begin
      merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: request decode and fault check, access FSM with ack
// timeout, and read-modify-write for sub-word stores on a word-only memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic        o_stb,
  output logic        o_wr_en,
  output logic [31:0] o_addr,
  output logic [31:0] o_write_data,
  input  logic        i_rd_ack,
  input  logic [31:0] i_read_data
);

  localparam int            CW       = cnt_width(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  lsu_state_e    state_q, state_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    off_q, off_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   write_data_q, write_data_d;

  logic          req_fault;
  logic [31:0]   load_data;
  logic [31:0]   merged_word;

  lsu_align u_align (
    .funct3      (funct3_q),
    .offset      (off_q),
    .read_word   (i_read_data),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    req_fault = 1'b0;
    if (i_we) begin
      case (i_funct3)
        F3_B:    req_fault = 1'b0;
        F3_H:    req_fault = i_addr[0];
        F3_W:    req_fault = |i_addr[1:0];
        default: req_fault = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        F3_B, F3_BU: req_fault = 1'b0;
        F3_H, F3_HU: req_fault = i_addr[0];
        F3_W:        req_fault = |i_addr[1:0];
        default:     req_fault = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    cnt_d        = '0;
    done_d       = 1'b0;
    fault_d      = 1'b0;
    rdata_d      = rdata_q;
    addr_d       = addr_q;
    write_data_d = write_data_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          if (req_fault) begin
            fault_d = 1'b1;
          end else begin
            funct3_d = i_funct3;
            off_d    = i_addr[1:0];
            wdata_d  = i_wdata[15:0];
            addr_d   = {i_addr[31:2], 2'b00};
            if (!i_we) begin
              state_d = ST_LOAD;
            end else if (i_funct3 == F3_W) begin
              state_d      = ST_WRITE;
              write_data_d = i_wdata;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
      end
      ST_LOAD, ST_FETCH: begin
        if (i_rd_ack) begin
          if (state_q == ST_LOAD) begin
            rdata_d = load_data;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            write_data_d = merged_word;
            state_d      = ST_WRITE;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abort after ACK_TIMEOUT strobe cycles; no write, result untouched.
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WRITE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      funct3_q     <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      rdata_q      <= '0;
      addr_q       <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      rdata_q      <= rdata_d;
      addr_q       <= addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign o_busy       = (state_q != ST_IDLE);
  assign o_stb        = (state_q == ST_LOAD) || (state_q == ST_FETCH);
  assign o_wr_en      = (state_q == ST_WRITE);
  assign o_done       = done_q;
  assign o_fault      = fault_q;
  assign o_rdata      = rdata_q;
  assign o_addr       = addr_q;
  assign o_write_data = write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses checked against a word-array memory and arithmetic reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_fault;
  logic        o_stb;
  logic        o_wr_en;
  logic [31:0] o_addr;
  logic [31:0] o_write_data;
  logic        i_rd_ack;
  logic [31:0] i_read_data;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:15];
  logic [31:0] last_rdata;

  int          res_done, res_fault, res_stb, res_wr, res_busy;
  logic [31:0] res_wr_addr, res_wr_data, res_stb_addr, res_rdata;

  load_store_unit #(.ACK_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (i_req),
    .i_we         (i_we),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rdata      (o_rdata),
    .o_fault      (o_fault),
    .o_stb        (o_stb),
    .o_wr_en      (o_wr_en),
    .o_addr       (o_addr),
    .o_write_data (o_write_data),
    .i_rd_ack     (i_rd_ack),
    .i_read_data  (i_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: access legality, load extension and store merge.
  function automatic logic ref_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned size;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
    size = 1 << (f3 % 4);
    return (addr % size) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
    int unsigned nbits, shift;
    logic [31:0] mask, v;
    nbits = 8 << (f3 % 4);
    if (nbits >= 32) return word;
    shift = 8 * (addr % 4);
    mask  = (32'd1 << nbits) - 32'd1;
    v     = (word >> shift) & mask;
    if (f3 < 3'd4 && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] old, input logic [31:0] wdata);
    int unsigned shift;
    logic [31:0] mask;
    if (f3 == 3'd2) return wdata;
    mask  = (f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
    shift = 8 * (addr % 4);
    return (old & ~(mask << shift)) | ((wdata & mask) << shift);
  endfunction

  // Issues one request and plays the memory side, recording what the DUT did
  // until it reports done or fault (bounded to 40 cycles).
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_delay);
    res_done = -1; res_fault = -1; res_stb = 0; res_wr = 0; res_busy = 0;
    res_wr_addr = 0; res_wr_data = 0; res_stb_addr = 0; res_rdata = 0;
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata; i_rd_ack = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      i_req = 1'b0; i_we = 1'($urandom); i_funct3 = 3'($urandom);
      i_addr = $urandom; i_wdata = $urandom;
      if (o_busy) res_busy++;
      if (o_wr_en) begin
        res_wr++; res_wr_addr = o_addr; res_wr_data = o_write_data;
      end
      if (o_stb) begin
        res_stb_addr = o_addr;
        i_rd_ack     = (res_stb == ack_delay);
        i_read_data  = i_rd_ack ? mem[o_addr[5:2]] : $urandom;
        res_stb++;
      end else begin
        i_rd_ack    = 1'($urandom);
        i_read_data = $urandom;
      end
      if (o_done) begin res_done = c; res_rdata = o_rdata; break; end
      if (o_fault) begin res_fault = c; res_rdata = o_rdata; break; end
    end
    i_rd_ack = 1'b0;
  endtask

  task automatic test_reset;
    tests_run++;
    if ({o_busy, o_done, o_fault, o_stb, o_wr_en, o_addr, o_write_data, o_rdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got ctl=%b addr=%h wd=%h rd=%h expected all zero",
               {o_busy, o_done, o_fault, o_stb, o_wr_en}, o_addr, o_write_data, o_rdata);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({o_busy, o_done, o_fault, o_stb, o_wr_en} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: got ctl=%b expected 00000", {o_busy, o_done, o_fault, o_stb, o_wr_en});
    end
    last_rdata = 32'h0;
  endtask

  task automatic test_store_word;
    run_access(1'b1, 3'b010, 32'd32, 32'd1234, 0);
    tests_run++;
    if ({res_done, res_fault, res_stb, res_wr, res_busy} !== {32'sd2, -32'sd1, 32'sd0, 32'sd1, 32'sd1}) begin
      tests_failed++;
      $display("[TB] FAIL sw_timing: got done/fault/stb/wr/busy %0d/%0d/%0d/%0d/%0d expected 2/-1/0/1/1",
               res_done, res_fault, res_stb, res_wr, res_busy);
    end
    tests_run++;
    if ({res_wr_addr, res_wr_data} !== {32'd32, 32'd1234}) begin
      tests_failed++;
      $display("[TB] FAIL sw_data: got addr=%0d data=%0d expected addr=32 data=1234", res_wr_addr, res_wr_data);
    end
    mem[8] = 32'd1234;
  endtask

  task automatic test_load_word;
    mem[4] = 32'd5678;
    run_access(1'b0, 3'b010, 32'd16, 32'h0, 2);
    tests_run++;
    if ({res_done, res_fault, res_stb, res_wr, res_busy, o_stb} !==
        {32'sd4, -32'sd1, 32'sd3, 32'sd0, 32'sd3, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL lw_timing: got done/fault/stb/wr/busy/stb_now %0d/%0d/%0d/%0d/%0d/%b expected 4/-1/3/0/3/0",
               res_done, res_fault, res_stb, res_wr, res_busy, o_stb);
    end
    tests_run++;
    if ({res_rdata, res_stb_addr} !== {32'd5678, 32'd16}) begin
      tests_failed++;
      $display("[TB] FAIL lw_data: got rdata=%0d addr=%0d expected rdata=5678 addr=16", res_rdata, res_stb_addr);
    end
    last_rdata = 32'd5678;
  endtask

  task automatic test_store_byte;
    mem[8] = 32'h1122_3344;
    run_access(1'b1, 3'b000, 32'd33, 32'h5A5A_5AAB, 1);
    tests_run++;
    if ({res_done, res_fault, res_stb, res_wr, res_busy} !== {32'sd4, -32'sd1, 32'sd2, 32'sd1, 32'sd3}) begin
      tests_failed++;
      $display("[TB] FAIL sb_timing: got done/fault/stb/wr/busy %0d/%0d/%0d/%0d/%0d expected 4/-1/2/1/3",
               res_done, res_fault, res_stb, res_wr, res_busy);
    end
    tests_run++;
    if ({res_stb_addr, res_wr_addr, res_wr_data} !== {32'd32, 32'd32, 32'h1122_AB44}) begin
      tests_failed++;
      $display("[TB] FAIL sb_data: got fetch=%0d waddr=%0d wdata=%h expected fetch=32 waddr=32 wdata=1122ab44",
               res_stb_addr, res_wr_addr, res_wr_data);
    end
    mem[8] = 32'h1122_AB44;
  endtask

  task automatic test_extend;
    logic [2:0]  f3s  [3] = '{3'b000, 3'b100, 3'b001};
    logic [31:0] adrs [3] = '{32'd35, 32'd35, 32'd34};
    logic [31:0] exps [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
    mem[8] = 32'h80FF_0000;
    for (int i = 0; i < 3; i++) begin
      run_access(1'b0, f3s[i], adrs[i], 32'h0, 0);
      tests_run++;
      if ({res_done, res_rdata} !== {32'sd2, exps[i]}) begin
        tests_failed++;
        $display("[TB] FAIL extend_%0d: got done=%0d rdata=%h expected done=2 rdata=%h", i, res_done, res_rdata, exps[i]);
      end
      last_rdata = exps[i];
    end
  endtask

  task automatic test_fault;
    logic        wes  [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s  [3] = '{3'b001, 3'b011, 3'b011};
    logic [31:0] adrs [3] = '{32'd17, 32'd16, 32'd16};
    for (int i = 0; i < 3; i++) begin
      run_access(wes[i], f3s[i], adrs[i], $urandom, 0);
      tests_run++;
      if ({res_done, res_fault, res_stb, res_wr, res_busy, res_rdata} !==
          {-32'sd1, 32'sd1, 32'sd0, 32'sd0, 32'sd0, last_rdata}) begin
        tests_failed++;
        $display("[TB] FAIL fault_%0d: got done/fault/stb/wr/busy %0d/%0d/%0d/%0d/%0d rdata=%h expected -1/1/0/0/0 rdata=%h",
                 i, res_done, res_fault, res_stb, res_wr, res_busy, res_rdata, last_rdata);
      end
    end
  endtask

  task automatic test_timeout;
    logic        wes  [2] = '{1'b0, 1'b1};
    logic [2:0]  f3s  [2] = '{3'b010, 3'b000};
    logic [31:0] adrs [2] = '{32'd20, 32'd21};
    for (int i = 0; i < 2; i++) begin
      run_access(wes[i], f3s[i], adrs[i], $urandom, -1);
      tests_run++;
      if ({res_done, res_fault, res_stb, res_wr, res_busy, res_rdata} !==
          {-32'sd1, 32'sd5, 32'sd4, 32'sd0, 32'sd4, last_rdata}) begin
        tests_failed++;
        $display("[TB] FAIL timeout_%0d: got done/fault/stb/wr/busy %0d/%0d/%0d/%0d/%0d rdata=%h expected -1/5/4/0/4 rdata=%h",
                 i, res_done, res_fault, res_stb, res_wr, res_busy, res_rdata, last_rdata);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] val;
    val = $urandom;
    run_access(1'b1, 3'b010, 32'd44, val, 0);
    tests_run++;
    if ({res_done, res_wr, res_wr_data} !== {32'sd2, 32'sd1, val}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_store: got done=%0d wr=%0d data=%h expected done=2 wr=1 data=%h", res_done, res_wr, res_wr_data, val);
    end
    mem[11] = val;
    run_access(1'b0, 3'b010, 32'd44, 32'h0, 0);
    tests_run++;
    if ({res_done, res_stb, res_rdata} !== {32'sd2, 32'sd1, val}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_load: got done=%0d stb=%0d rdata=%h expected done=2 stb=1 rdata=%h", res_done, res_stb, res_rdata, val);
    end
    last_rdata = val;
  endtask

  task automatic test_reset_in_fetch;
    int wr_seen;
    mem[9] = 32'h0102_0304;
    i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b001; i_addr = 32'd38; i_wdata = 32'hBEEF;
    @(posedge clk); #1;
    i_req = 1'b0;
    tests_run++;
    if ({o_stb, o_wr_en} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL rst_fetch_entry: got stb/wr=%b expected 10", {o_stb, o_wr_en});
    end
    rst_n = 1'b0; i_rd_ack = 1'b1; i_read_data = mem[9];
    @(posedge clk); #1;
    rst_n = 1'b1; i_rd_ack = 1'b0;
    tests_run++;
    if ({o_busy, o_done, o_fault, o_stb, o_wr_en, o_addr, o_write_data, o_rdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rst_fetch_clear: got ctl=%b addr=%h wd=%h rd=%h expected all zero",
               {o_busy, o_done, o_fault, o_stb, o_wr_en}, o_addr, o_write_data, o_rdata);
    end
    last_rdata = 32'h0;
    wr_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (o_wr_en || o_busy) wr_seen++;
    end
    tests_run++;
    if (wr_seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL rst_fetch_nowrite: got %0d active cycles expected 0", wr_seen);
    end
    run_access(1'b0, 3'b010, 32'd36, 32'h0, 1);
    tests_run++;
    if ({res_done, res_stb, res_wr, res_rdata} !== {32'sd3, 32'sd2, 32'sd0, 32'h0102_0304}) begin
      tests_failed++;
      $display("[TB] FAIL rst_fetch_reload: got done=%0d stb=%0d wr=%0d rdata=%h expected 3/2/0/01020304",
               res_done, res_stb, res_wr, res_rdata);
    end
    last_rdata = 32'h0102_0304;
  endtask

  task automatic test_random;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, aligned, exp_word;
    int          d;
    int          e_done, e_fault, e_stb, e_wr, e_busy;
    logic [31:0] e_rd, e_saddr, e_waddr, e_wdata;
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom); f3 = 3'($urandom); addr = $urandom % 64; wdata = $urandom; d = $urandom % 4;
      aligned = addr & ~32'd3;
      e_rd = last_rdata; e_saddr = 0; e_waddr = 0; e_wdata = 0;
      if (ref_fault(we, f3, addr)) begin
        e_done = -1; e_fault = 1; e_stb = 0; e_wr = 0; e_busy = 0;
      end else if (!we) begin
        e_done = d + 2; e_fault = -1; e_stb = d + 1; e_wr = 0; e_busy = d + 1;
        e_rd = ref_load(f3, addr, mem[addr / 4]); e_saddr = aligned;
      end else if (f3 == 3'd2) begin
        e_done = 2; e_fault = -1; e_stb = 0; e_wr = 1; e_busy = 1;
        e_waddr = aligned; e_wdata = wdata;
      end else begin
        e_done = d + 3; e_fault = -1; e_stb = d + 1; e_wr = 1; e_busy = d + 2;
        e_saddr = aligned; e_waddr = aligned; e_wdata = ref_store(f3, addr, mem[addr / 4], wdata);
      end
      run_access(we, f3, addr, wdata, d);
      tests_run++;
      if ({res_done, res_fault, res_stb, res_wr, res_busy} !== {e_done, e_fault, e_stb, e_wr, e_busy}) begin
        tests_failed++;
        $display("[TB] FAIL rand_timing_%0d (we=%b f3=%0d addr=%0d d=%0d): got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                 n, we, f3, addr, d, res_done, res_fault, res_stb, res_wr, res_busy, e_done, e_fault, e_stb, e_wr, e_busy);
      end
      tests_run++;
      if ({res_rdata, res_stb_addr, res_wr_addr, res_wr_data} !== {e_rd, e_saddr, e_waddr, e_wdata}) begin
        tests_failed++;
        $display("[TB] FAIL rand_data_%0d (we=%b f3=%0d addr=%0d): got %h/%h/%h/%h expected %h/%h/%h/%h",
                 n, we, f3, addr, res_rdata, res_stb_addr, res_wr_addr, res_wr_data, e_rd, e_saddr, e_waddr, e_wdata);
      end
      last_rdata = e_rd;
      if (e_wr == 1) begin
        exp_word = e_wdata;
        mem[addr / 4] = exp_word;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b0; i_addr = 32'h0;
    i_wdata = 32'h0; i_rd_ack = 1'b0; i_read_data = 32'h0; last_rdata = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_store_word;
    test_load_word;
    test_store_byte;
    test_extend;
    test_fault;
    test_timeout;
    test_back_to_back;
    test_reset_in_fetch;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the data memory port. It turns RV32I load/store requests from the execute stage into word-wide strobe/write transactions on the data memory, handles byte-lane alignment and sign/zero extension, and stalls the pipeline until each access completes. The memory has no byte enables, so sub-word stores are done as read-modify-write.

## Interface
- `ACK_TIMEOUT`, default 255: maximum number of cycles `o_stb` stays high without `i_rd_ack` before the access is aborted with a fault.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `i_req`  in  1  access request from execute; sampled only in IDLE.
- `i_we`  in  1  1 = store, 0 = load.
- `i_funct3`  in  3  RV32I width/sign code:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW.
- `i_addr`  in  32  byte address.
- `i_wdata`  in  32  store data, low-aligned.
- `o_busy`  out  1  stall; high whenever state ≠ IDLE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_rdata`  out  32  extended load result; valid with `o_done`, held until the next load completes.
- `o_fault`  out  1  one-cycle pulse for a misaligned address, illegal funct3, or ack timeout.
- `o_stb`  out  1  memory read strobe.
- `o_wr_en`  out  1  memory write enable.
- `o_addr`  out  32  word-aligned byte address, `{i_addr[31:2],2'b00}`.
- `o_write_data`  out  32  full write word.
- `i_rd_ack`  in  1  memory read acknowledge.
- `i_read_data`  in  32  memory read word; valid when `i_rd_ack` is high.

## Operation
- States:
  - IDLE: waits for a request.
  - LOAD: `o_stb`=1; waits for `i_rd_ack`.
  - FETCH: `o_stb`=1; reads the old word for SB/SH.
  - WRITE: `o_wr_en`=1 for exactly one cycle, `o_stb`=0.
- Transitions from IDLE when `i_req`=1:
  - load → LOAD;
  - SW → WRITE;
  - SB/SH → FETCH;
  - fault condition → stay in IDLE, pulse `o_fault` next cycle, no memory activity.
- Fault conditions:
  - LH/LHU/SH with `addr[0]`=1;
  - LW/SW with `addr[1:0]`≠0;
  - load funct3 011/110/111;
  - store funct3 other than 000–010.
- LOAD + `i_rd_ack` → IDLE.
  - Byte k = `addr[1:0]` and halfword h = `addr[1]` are extracted from `i_read_data`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- FETCH + `i_rd_ack` → WRITE.
  - The merged word is registered from `i_read_data`, with byte lane k (SB) or halfword lane h (SH) replaced by `i_wdata[7:0]` / `[15:0]`.
  - SW writes `i_wdata` unmerged.
- Little-endian: byte k occupies bits `[8k+7:8k]`.
- Request fields are registered on acceptance. `i_*` changes while busy are ignored.
- `i_rd_ack` is ignored in IDLE and WRITE.
- Timeout:
  - A cycle counter runs in LOAD/FETCH and is cleared on state entry.
  - If `ACK_TIMEOUT` cycles elapse without an ack, go to IDLE and pulse `o_fault`.
  - No write is issued and `o_rdata` is unchanged.

## Timing
- Reset values: state IDLE; `o_busy`, `o_done`, `o_fault`, `o_stb`, `o_wr_en` = 0; `o_addr`, `o_write_data`, `o_rdata` = 0; timeout counter 0.
- `o_stb`/`o_wr_en` are decoded from the registered state. `o_done`/`o_fault` are registered pulses.
- A request accepted at edge E0 drives memory from cycle 1 onward.
- SW: WRITE in cycle 1; IDLE with `o_done`=1 in cycle 2.
- Load with ack in cycle k (k ≥ 1): IDLE with `o_done` and `o_rdata` valid in cycle k+1.
- SB/SH with ack in cycle k: WRITE in cycle k+1; `o_done` in cycle k+2.
- Fault on request: `o_fault` in cycle 1.
- Timeout: `o_stb` is high for exactly `ACK_TIMEOUT` cycles; `o_fault` in the following cycle, when the unit is back in IDLE.
- Back-to-back: a new `i_req` is accepted in the same cycle `o_done` is high.
- `rst_n`=0 at any edge → IDLE next cycle.
  - An in-flight FETCH never produces a write.
  - A pending `o_done`/`o_fault` is cancelled.

## Structure
- Package `lsu_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - state enum (`ST_IDLE`, `ST_LOAD`, `ST_FETCH`, `ST_WRITE`);
  - timeout counter width, `$clog2(ACK_TIMEOUT+1)`.
- Sub-module `lsu_align` (combinational): load extract/extend and store merge. The top level contains the FSM, request registers and timeout counter.

## Test plan
- SW 1234 to addr 32 → `o_wr_en`=1, `o_addr`=32, `o_write_data`=1234 in cycle 1 only; `o_done` in cycle 2; `o_stb` never high.
- LW addr 16, ack 2 cycles after `o_stb` rises with 5678 → `o_rdata`=5678 and `o_done` one cycle after ack; `o_stb` low from then.
- SB 0xAB to addr 33, memory word 0x11223344 → FETCH at addr 32, then a single write of 0x1122AB44 to addr 32; `o_done` after the write cycle.
- Word 0x80FF0000 at addr 32:
  - LB addr 35 → 0xFFFFFF80;
  - LBU addr 35 → 0x00000080;
  - LH addr 34 → 0xFFFF80FF.
- Faults:
  - LH addr 17 → `o_fault` cycle 1, no `o_stb`/`o_wr_en`, `o_rdata` unchanged;
  - load funct3 011 → same response;
  - `ACK_TIMEOUT`=4 with no ack → `o_stb` high 4 cycles, then `o_fault`, IDLE.
- `rst_n`=0 during FETCH of an SH → IDLE next cycle, all outputs 0, no `o_wr_en` pulse ever; a fresh LW afterwards completes normally.
